// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the divider sequencer
// Purpose: state encoding, datapath width, divide-by-zero quotient and
// default timeout used by div_sequencer and its helpers. No ports.
package div_pkg;

    localparam int DIV_WIDTH   = 16;
    localparam int DIV_ITER    = 16;
    localparam int DIV_TIMEOUT = 40;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_DVD = 3'd1,
        S_LD_DVS = 3'd2,
        S_START  = 3'd3,
        S_RUN    = 3'd4,
        S_RESP   = 3'd5
    } div_seq_state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - request/response and divider-bus bundle
// Purpose: groups the request channel, response channel, status and the
// divider control bus of div_sequencer.
// Modports: master = sequencer side (drives req_ready, rsp_*, busy, div_*
// strobes/data); slave = environment side (drives req_*, rsp_ready and the
// divider results).
interface div_sequencer_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_dividend;
    logic [WIDTH-1:0] req_divisor;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_quotient;
    logic [WIDTH-1:0] rsp_remainder;
    logic             rsp_div0;
    logic             rsp_timeout;

    logic             busy;

    logic [WIDTH-1:0] div_data;
    logic             div_load_dividend;
    logic             div_load_divisor;
    logic             div_start;
    logic             div_enable;
    logic             div_ready;
    logic [WIDTH-1:0] div_result;
    logic [WIDTH-1:0] div_residue;

    modport master (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
               div_ready, div_result, div_residue,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder,
               rsp_div0, rsp_timeout, busy, div_data,
               div_load_dividend, div_load_divisor, div_start, div_enable
    );

    modport slave (
        output req_valid, req_dividend, req_divisor, rsp_ready,
               div_ready, div_result, div_residue,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder,
               rsp_div0, rsp_timeout, busy, div_data,
               div_load_dividend, div_load_divisor, div_start, div_enable
    );

endinterface

// File: rtl/div_seq_counter.sv
// rtl/div_seq_counter.sv - clearable enabled up-counter with terminal count
// Purpose: measures RUN cycles for the divider timeout.
// Ports: clk, rst (async active-low), clr_i (sync clear, wins over en_i),
// en_i (count enable), tc_o (count equals TIMEOUT-1).
module div_seq_counter
    import div_pkg::*;
#(
    parameter  int TIMEOUT = DIV_TIMEOUT,
    localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - control sequencer for the iterative divider
// Purpose: accepts one division request, loads dividend then divisor onto
// the shared divider bus, pulses start, holds enable until div_ready (or a
// timeout), and returns quotient/remainder with div0/timeout flags.
// Ports: clk, rst (async active-low); bus (div_sequencer_if.master) carries
// the request, response, busy and divider-bus signals.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int ITER    = DIV_ITER,
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    div_sequencer_if.master   bus
);

    div_seq_state_t   state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div0_q, div0_d;
    logic             tmo_q, tmo_d;
    logic             req_ready_q, req_ready_d;
    logic             cnt_tc;

    div_seq_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == S_START),
        .en_i  (state_q == S_RUN),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    dvd_d = bus.req_dividend;
                    dvs_d = bus.req_divisor;
                    if (bus.req_divisor == '0) begin
                        quo_d   = DIV0_QUOTIENT;
                        rem_d   = bus.req_dividend;
                        div0_d  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LD_DVD;
                    end
                end
            end
            S_LD_DVD: state_d = S_LD_DVS;
            S_LD_DVS: state_d = S_START;
            S_START:  state_d = S_RUN;
            S_RUN: begin
                // A result arriving on the timeout cycle is still taken.
                if (bus.div_ready) begin
                    quo_d   = bus.div_result;
                    rem_d   = bus.div_residue;
                    state_d = S_RESP;
                end else if (cnt_tc) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    div0_d  = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registered so req_ready stays low while reset is asserted.
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            div0_q      <= 1'b0;
            tmo_q       <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            div0_q      <= div0_d;
            tmo_q       <= tmo_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign bus.req_ready         = req_ready_q;
    assign bus.busy              = (state_q != S_IDLE);
    assign bus.rsp_valid         = (state_q == S_RESP);
    assign bus.rsp_quotient      = quo_q;
    assign bus.rsp_remainder     = rem_q;
    assign bus.rsp_div0          = div0_q;
    assign bus.rsp_timeout       = tmo_q;
    assign bus.div_load_dividend = (state_q == S_LD_DVD);
    assign bus.div_load_divisor  = (state_q == S_LD_DVS);
    assign bus.div_start         = (state_q == S_START);
    assign bus.div_enable        = (state_q == S_RUN);
    assign bus.div_data          = (state_q == S_LD_DVD) ? dvd_q :
                                   (state_q == S_LD_DVS) ? dvs_q : '0;

    // The divider's nominal run must complete inside the timeout window.
    a_iter_fits_timeout: assert property (@(posedge clk) disable iff (!rst) ITER < TIMEOUT);

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Upstream control stage for the 16-bit iterative divider datapath. It accepts one division request per transaction on a valid/ready interface. It then serialises the two operands onto the divider's shared data bus, pulses start, and holds enable until the divider reports ready. It captures quotient and remainder, and returns them on a valid/ready response interface, trapping divide-by-zero and a hung divider.

Parameters:
WIDTH, 16, operand/result width; must match the divider datapath
ITER, 16, nominal divider iterations; informational, used by bench and assertions only
TIMEOUT, 40, maximum RUN cycles waited for div_ready before aborting

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_dividend  in  WIDTH  two's-complement dividend
req_divisor  in  WIDTH  two's-complement divisor
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_quotient  out  WIDTH  captured quotient
rsp_remainder  out  WIDTH  captured remainder
rsp_div0  out  1  response is a divide-by-zero trap
rsp_timeout  out  1  response is a timeout abort
busy  out  1  transaction in progress (state != IDLE)
div_data  out  WIDTH  shared operand bus to divider
div_load_dividend  out  1  one-cycle load strobe, dividend register
div_load_divisor  out  1  one-cycle load strobe, divisor register
div_start  out  1  one-cycle start pulse
div_enable  out  1  iteration enable, held high through RUN
div_ready  in  1  divider done flag
div_result  in  WIDTH  divider quotient
div_residue  in  WIDTH  divider remainder

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0; operand, result and timeout registers cleared. Reset mid-transaction aborts it silently; no response is produced.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- States: IDLE, LD_DVD, LD_DVS, START, RUN, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch both operands.
  - Divisor==0: go to RESP with quotient={WIDTH{1}}, remainder=dividend, rsp_div0=1. No div_* strobe is issued.
  - Otherwise: go to LD_DVD.
- LD_DVD (1 cycle): div_data=dividend, div_load_dividend=1.
- LD_DVS (1 cycle): div_data=divisor, div_load_divisor=1.
- START (1 cycle): div_start=1, div_data=0. Clear the timeout counter.
- RUN: div_enable=1 and the counter increments each cycle.
  - div_ready=1: capture div_result/div_residue on that edge, go to RESP. div_enable drops in the next cycle.
  - Counter reaches TIMEOUT-1 without div_ready: go to RESP with quotient=0, remainder=0, rsp_timeout=1.
  - div_ready and timeout in the same cycle: div_ready wins.
- RESP: rsp_valid=1, and payload and flags are held stable until rsp_ready. On rsp_valid&rsp_ready go to IDLE and clear the flags.
- req_ready=0 in RESP, so a new request is accepted no earlier than the cycle after the response handshake.
- div_data is 0 whenever no load strobe is active.
- Nominal latency: accept at cycle 0; loads at cycles 1 and 2; start at cycle 3; enable from cycle 4; rsp_valid in the cycle after div_ready is sampled.
- Divide-by-zero: rsp_valid is high in the cycle after acceptance.
- Sign handling belongs to the divider; operands pass through unmodified.
- div_ready is ignored outside RUN.

Decomposition:
- Package div_pkg:
  - state enum div_seq_state_t
  - DIV_WIDTH=16
  - DIV0_QUOTIENT all-ones constant
  - default TIMEOUT
- Sub-module div_seq_counter: clearable, enabled up-counter of width clog2(TIMEOUT) with a terminal-count output. Used for the RUN timeout.

Test Plan:
- Bench divider model: loads on the strobes, asserts div_ready after ITER enable cycles, returns the true quotient/remainder.
- 100/7 -> loads at cycles 1-2, start at 3, rsp_quotient=14, rsp_remainder=2, flags 0.
- -100/7 -> quotient and remainder from the model passed through unchanged (16'hFFF2, 16'hFFFE). No div_load or div_enable glitch.
- 1234/0 -> rsp_valid one cycle after accept; quotient 16'hFFFF, remainder 1234, rsp_div0=1; no div_* strobe ever asserted.
- Model never asserts div_ready -> rsp_valid after exactly TIMEOUT RUN cycles, rsp_timeout=1, payload 0.
- rsp_ready held low 10 cycles -> payload stable; req_ready stays 0; a request presented meanwhile is accepted only after the handshake.
- rst pulsed low during RUN -> all outputs 0 immediately. After release: IDLE, req_ready=1, and no stale response emitted.
